// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: opcodes, ALUOp encodings and ID/EX control-bundle layout.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam int unsigned WB_W = 2;
    localparam int unsigned M_W  = 3;
    localparam int unsigned EX_W = 4;

    localparam int unsigned WB_REGWRITE = 1;
    localparam int unsigned WB_MEMTOREG = 0;

    localparam int unsigned M_BRANCH   = 2;
    localparam int unsigned M_MEMREAD  = 1;
    localparam int unsigned M_MEMWRITE = 0;

    localparam int unsigned EX_REGDST   = 3;
    localparam int unsigned EX_ALUOP_HI = 2;
    localparam int unsigned EX_ALUOP_LO = 1;
    localparam int unsigned EX_ALUSRC   = 0;

endpackage

// File: rtl/regfile.sv
// Register file with r0 hardwired to zero and write-through bypass on both read ports.
module regfile #(
    parameter int unsigned NREG = 32,
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = $clog2(NREG)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_a_i,
    input  logic [AW-1:0] raddr_b_i,
    output logic [DW-1:0] rdata_a_o,
    output logic [DW-1:0] rdata_b_o
);

    logic [DW-1:0] mem_q [NREG];
    logic          wr_en;

    assign wr_en = we_i && (waddr_i != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NREG); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Bypass lets the reader see a value being written back in the same cycle.
    always_comb begin
        rdata_a_o = mem_q[raddr_a_i];
        if (raddr_a_i == '0) begin
            rdata_a_o = '0;
        end else if (wr_en && (waddr_i == raddr_a_i)) begin
            rdata_a_o = wdata_i;
        end
    end

    always_comb begin
        rdata_b_o = mem_q[raddr_b_i];
        if (raddr_b_i == '0) begin
            rdata_b_o = '0;
        end else if (wr_en && (waddr_i == raddr_b_i)) begin
            rdata_b_o = wdata_i;
        end
    end

endmodule

// File: rtl/i_decode.sv
// MIPS ID stage: control decode, register read, load-use stall, flush and the ID/EX register.
module i_decode
    import mips_pkg::*;
#(
    parameter int unsigned NREG = 32,
    parameter int unsigned DW   = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [31:0]     IF_ID_IR,
    input  logic [31:0]     IF_ID_NPC,
    input  logic            EX_MEM_PCSrc,
    input  logic            MEM_WB_RegWrite,
    input  logic [4:0]      MEM_WB_WriteReg,
    input  logic [DW-1:0]   MEM_WB_WriteData,
    output logic            stall,
    output logic [WB_W-1:0] ID_EX_WB,
    output logic [M_W-1:0]  ID_EX_M,
    output logic [EX_W-1:0] ID_EX_EX,
    output logic [31:0]     ID_EX_NPC,
    output logic [DW-1:0]   ID_EX_A,
    output logic [DW-1:0]   ID_EX_B,
    output logic [DW-1:0]   ID_EX_Imm,
    output logic [4:0]      ID_EX_rs,
    output logic [4:0]      ID_EX_rt,
    output logic [4:0]      ID_EX_rd
);

    logic [5:0]      opcode;
    logic [4:0]      rs, rt, rd;
    logic [DW-1:0]   rdata_a, rdata_b;
    logic [WB_W-1:0] wb_d, wb_q;
    logic [M_W-1:0]  m_d, m_q;
    logic [EX_W-1:0] ex_d, ex_q;
    logic [31:0]     npc_q;
    logic [DW-1:0]   a_q, b_q, imm_d, imm_q;
    logic [4:0]      rs_q, rt_q, rd_q;

    assign opcode = IF_ID_IR[31:26];
    assign rs     = IF_ID_IR[25:21];
    assign rt     = IF_ID_IR[20:16];
    assign rd     = IF_ID_IR[15:11];
    assign imm_d  = {{(DW-16){IF_ID_IR[15]}}, IF_ID_IR[15:0]};

    regfile #(
        .NREG (NREG),
        .DW   (DW)
    ) u_regfile (
        .clk_i     (clock),
        .rst_ni    (reset),
        .we_i      (MEM_WB_RegWrite),
        .waddr_i   (MEM_WB_WriteReg),
        .wdata_i   (MEM_WB_WriteData),
        .raddr_a_i (rs),
        .raddr_b_i (rt),
        .rdata_a_o (rdata_a),
        .rdata_b_o (rdata_b)
    );

    assign stall = m_q[M_MEMREAD] && (rt_q != 5'd0) && ((rt_q == rs) || (rt_q == rt));

    always_comb begin
        wb_d = '0;
        m_d  = '0;
        ex_d = '0;
        unique case (opcode)
            OP_RTYPE: begin
                ex_d[EX_REGDST]                = 1'b1;
                ex_d[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_FUNCT;
                wb_d[WB_REGWRITE]              = 1'b1;
            end
            OP_LW: begin
                ex_d[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_ADD;
                ex_d[EX_ALUSRC]                = 1'b1;
                m_d[M_MEMREAD]                 = 1'b1;
                wb_d[WB_REGWRITE]              = 1'b1;
                wb_d[WB_MEMTOREG]              = 1'b1;
            end
            OP_SW: begin
                ex_d[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_ADD;
                ex_d[EX_ALUSRC]                = 1'b1;
                m_d[M_MEMWRITE]                = 1'b1;
            end
            OP_BEQ: begin
                ex_d[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_SUB;
                m_d[M_BRANCH]                  = 1'b1;
            end
            default: ;
        endcase
        // An all-zero IR is an R-type encoding but must decode as a nop.
        if (IF_ID_IR == 32'd0 || stall || EX_MEM_PCSrc) begin
            wb_d = '0;
            m_d  = '0;
            ex_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb_q  <= '0;
            m_q   <= '0;
            ex_q  <= '0;
            npc_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            imm_q <= '0;
            rs_q  <= '0;
            rt_q  <= '0;
            rd_q  <= '0;
        end else begin
            wb_q  <= wb_d;
            m_q   <= m_d;
            ex_q  <= ex_d;
            npc_q <= IF_ID_NPC;
            a_q   <= rdata_a;
            b_q   <= rdata_b;
            imm_q <= imm_d;
            rs_q  <= rs;
            rt_q  <= rt;
            rd_q  <= rd;
        end
    end

    assign ID_EX_WB  = wb_q;
    assign ID_EX_M   = m_q;
    assign ID_EX_EX  = ex_q;
    assign ID_EX_NPC = npc_q;
    assign ID_EX_A   = a_q;
    assign ID_EX_B   = b_q;
    assign ID_EX_Imm = imm_q;
    assign ID_EX_rs  = rs_q;
    assign ID_EX_rt  = rt_q;
    assign ID_EX_rd  = rd_q;

endmodule

// File: tb/tb_i_decode.sv
// Directed bench for i_decode: decode, register file, bypass, load-use stall, flush and reset.
module tb_i_decode;

    logic        clock;
    logic        reset;
    logic [31:0] IF_ID_IR;
    logic [31:0] IF_ID_NPC;
    logic        EX_MEM_PCSrc;
    logic        MEM_WB_RegWrite;
    logic [4:0]  MEM_WB_WriteReg;
    logic [31:0] MEM_WB_WriteData;
    logic        stall;
    logic [1:0]  ID_EX_WB;
    logic [2:0]  ID_EX_M;
    logic [3:0]  ID_EX_EX;
    logic [31:0] ID_EX_NPC;
    logic [31:0] ID_EX_A;
    logic [31:0] ID_EX_B;
    logic [31:0] ID_EX_Imm;
    logic [4:0]  ID_EX_rs;
    logic [4:0]  ID_EX_rt;
    logic [4:0]  ID_EX_rd;

    int errors = 0;
    int checks = 0;

    i_decode dut (
        .clock            (clock),
        .reset            (reset),
        .IF_ID_IR         (IF_ID_IR),
        .IF_ID_NPC        (IF_ID_NPC),
        .EX_MEM_PCSrc     (EX_MEM_PCSrc),
        .MEM_WB_RegWrite  (MEM_WB_RegWrite),
        .MEM_WB_WriteReg  (MEM_WB_WriteReg),
        .MEM_WB_WriteData (MEM_WB_WriteData),
        .stall            (stall),
        .ID_EX_WB         (ID_EX_WB),
        .ID_EX_M          (ID_EX_M),
        .ID_EX_EX         (ID_EX_EX),
        .ID_EX_NPC        (ID_EX_NPC),
        .ID_EX_A          (ID_EX_A),
        .ID_EX_B          (ID_EX_B),
        .ID_EX_Imm        (ID_EX_Imm),
        .ID_EX_rs         (ID_EX_rs),
        .ID_EX_rt         (ID_EX_rt),
        .ID_EX_rd         (ID_EX_rd)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_ctrl(input string tag, input logic [1:0] wb, input logic [2:0] m,
                            input logic [3:0] ex);
        chk({tag, ".WB"}, {30'd0, ID_EX_WB}, {30'd0, wb});
        chk({tag, ".M"},  {29'd0, ID_EX_M},  {29'd0, m});
        chk({tag, ".EX"}, {28'd0, ID_EX_EX}, {28'd0, ex});
    endtask

    task automatic chk_all_zero(input string tag);
        chk_ctrl(tag, 2'b00, 3'b000, 4'b0000);
        chk({tag, ".NPC"}, ID_EX_NPC, 32'd0);
        chk({tag, ".A"},   ID_EX_A,   32'd0);
        chk({tag, ".B"},   ID_EX_B,   32'd0);
        chk({tag, ".Imm"}, ID_EX_Imm, 32'd0);
        chk({tag, ".rs"},  {27'd0, ID_EX_rs}, 32'd0);
        chk({tag, ".rt"},  {27'd0, ID_EX_rt}, 32'd0);
        chk({tag, ".rd"},  {27'd0, ID_EX_rd}, 32'd0);
        chk({tag, ".stall"}, {31'd0, stall}, 32'd0);
    endtask

    initial begin
        reset            = 1'b0;
        IF_ID_IR         = 32'd0;
        IF_ID_NPC        = 32'd0;
        EX_MEM_PCSrc     = 1'b0;
        MEM_WB_RegWrite  = 1'b0;
        MEM_WB_WriteReg  = 5'd0;
        MEM_WB_WriteData = 32'd0;
        #2;
        chk_all_zero("in_reset");
        #10 reset = 1'b1;

        // Nop after release
        step();
        chk_all_zero("nop");

        // Write r8, then decode add r10,r8,r9
        MEM_WB_RegWrite  = 1'b1;
        MEM_WB_WriteReg  = 5'd8;
        MEM_WB_WriteData = 32'h12345678;
        step();
        MEM_WB_RegWrite  = 1'b0;
        IF_ID_IR         = 32'h01095020;
        IF_ID_NPC        = 32'h00000104;
        step();
        chk_ctrl("add", 2'b10, 3'b000, 4'b1100);
        chk("add.A",   ID_EX_A,   32'h12345678);
        chk("add.B",   ID_EX_B,   32'd0);
        chk("add.NPC", ID_EX_NPC, 32'h00000104);
        chk("add.Imm", ID_EX_Imm, 32'h00005020);
        chk("add.rs",  {27'd0, ID_EX_rs}, 32'd8);
        chk("add.rt",  {27'd0, ID_EX_rt}, 32'd9);
        chk("add.rd",  {27'd0, ID_EX_rd}, 32'd10);

        // Same-cycle write to r9 is bypassed onto B
        MEM_WB_RegWrite  = 1'b1;
        MEM_WB_WriteReg  = 5'd9;
        MEM_WB_WriteData = 32'hDEADBEEF;
        step();
        chk("bypass.B", ID_EX_B, 32'hDEADBEEF);
        chk("bypass.A", ID_EX_A, 32'h12345678);

        // Write to r0 is ignored, including the bypass path
        MEM_WB_WriteReg  = 5'd0;
        MEM_WB_WriteData = 32'hFFFFFFFF;
        IF_ID_IR         = 32'h00005020;
        step();
        chk("r0_same.A", ID_EX_A, 32'd0);
        chk("r0_same.B", ID_EX_B, 32'd0);
        MEM_WB_RegWrite  = 1'b0;
        step();
        chk("r0_after.A", ID_EX_A, 32'd0);
        IF_ID_IR = 32'h01095020;
        step();
        chk("r9_stored.B", ID_EX_B, 32'hDEADBEEF);

        // Unsupported opcode (addi) decodes as nop but specifiers still register
        IF_ID_IR = 32'h21080001;
        step();
        chk_ctrl("addi", 2'b00, 3'b000, 4'b0000);
        chk("addi.rt", {27'd0, ID_EX_rt}, 32'd8);

        // sw r8,4(r9)
        IF_ID_IR = 32'hAD280004;
        step();
        chk_ctrl("sw", 2'b00, 3'b001, 4'b0001);

        // lw r8,-4(r9) then add using r8: one-cycle stall with bubble
        IF_ID_IR = 32'h8D28FFFC;
        step();
        chk_ctrl("lw", 2'b11, 3'b010, 4'b0001);
        chk("lw.Imm", ID_EX_Imm, 32'hFFFFFFFC);
        chk("lw.A",   ID_EX_A,   32'hDEADBEEF);
        IF_ID_IR = 32'h01095020;
        #1;
        chk("lu.stall", {31'd0, stall}, 32'd1);
        step();
        chk_ctrl("bubble", 2'b00, 3'b000, 4'b0000);
        chk("bubble.stall", {31'd0, stall}, 32'd0);
        step();
        chk_ctrl("add_after", 2'b10, 3'b000, 4'b1100);
        chk("add_after.A", ID_EX_A, 32'h12345678);
        chk("add_after.stall", {31'd0, stall}, 32'd0);

        // beq r1,r2,8 normally, then with flush
        IF_ID_IR = 32'h10220008;
        step();
        chk_ctrl("beq", 2'b00, 3'b100, 4'b0010);
        chk("beq.Imm", ID_EX_Imm, 32'h00000008);
        EX_MEM_PCSrc = 1'b1;
        step();
        chk_ctrl("beq_flush", 2'b00, 3'b000, 4'b0000);
        EX_MEM_PCSrc = 1'b0;

        // Flush during a load-use stall
        IF_ID_IR = 32'h8D28FFFC;
        step();
        chk_ctrl("lw2", 2'b11, 3'b010, 4'b0001);
        IF_ID_IR     = 32'h01095020;
        EX_MEM_PCSrc = 1'b1;
        #1;
        chk("flush_stall.stall", {31'd0, stall}, 32'd1);
        step();
        chk_ctrl("flush_stall", 2'b00, 3'b000, 4'b0000);
        EX_MEM_PCSrc = 1'b0;

        // Async reset mid-stream with a load in ID/EX
        IF_ID_IR = 32'h8D28FFFC;
        step();
        chk_ctrl("lw3", 2'b11, 3'b010, 4'b0001);
        #1 reset = 1'b0;
        #1;
        chk_all_zero("async_rst");
        #2 reset = 1'b1;
        IF_ID_IR  = 32'h01095020;
        IF_ID_NPC = 32'h00000200;
        step();
        chk_ctrl("post_rst", 2'b10, 3'b000, 4'b1100);
        chk("post_rst.A",   ID_EX_A,   32'd0);
        chk("post_rst.B",   ID_EX_B,   32'd0);
        chk("post_rst.NPC", ID_EX_NPC, 32'h00000200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
